// File: rtl/prog_resp_tx.sv
// Reply framer/transmitter for the programming command channel.
// Sends SOP CMD LEN_H LEN_L payload CHK EOP as back-to-back 8N1 bytes.
module prog_resp_tx #(
  parameter int          CLKS_PER_BIT = 217,
  parameter logic [7:0]  C_SOP        = 8'h23,
  parameter logic [7:0]  C_EOP        = 8'h0d,
  parameter logic [7:0]  C_RD         = 8'h08,
  parameter logic [7:0]  C_WR         = 8'h07
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOP,
    S_CMD,
    S_LENH,
    S_LENL,
    S_PAY,
    S_CHK,
    S_EOP,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cmd_q;
  logic [63:0] pl_q;
  logic [7:0]  cur_q;
  logic [15:0] baud_q;
  logic [3:0]  bit_q;
  logic [2:0]  pay_q;
  logic [7:0]  chk_q;

  logic        load;
  logic        add_chk;
  logic [7:0]  nbyte;
  logic        in_byte;
  logic        byte_end;
  logic        has_pay;
  logic [7:0]  len_l;
  logic [2:0]  len_m1;
  logic [2:0]  bit_idx;

  function automatic logic [7:0] pick(
    input logic [63:0] p,
    input logic [2:0]  k
  );
    logic [7:0] b;
    unique case (k)
      3'd0:    b = p[63:56];
      3'd1:    b = p[55:48];
      3'd2:    b = p[47:40];
      3'd3:    b = p[39:32];
      3'd4:    b = p[31:24];
      3'd5:    b = p[23:16];
      3'd6:    b = p[15:8];
      default: b = p[7:0];
    endcase
    return b;
  endfunction

  always_comb begin
    has_pay = 1'b1;
    len_l   = 8'h00;
    len_m1  = 3'd0;
    unique case (1'b1)
      (cmd_q == C_RD): begin
        len_l  = 8'h08;
        len_m1 = 3'd7;
      end
      (cmd_q == C_WR): begin
        len_l  = 8'h04;
        len_m1 = 3'd3;
      end
      default: has_pay = 1'b0;
    endcase
  end

  assign in_byte  = (state != S_IDLE) && (state != S_DONE);
  assign byte_end = in_byte && (baud_q == BAUD_MAX) && (bit_q == 4'd9);
  assign bit_idx  = bit_q[2:0] - 3'd1;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    add_chk   = 1'b0;
    nbyte     = 8'h00;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = S_SOP;
          load      = 1'b1;
          nbyte     = C_SOP;
        end
      end
      S_SOP: begin
        if (byte_end) begin
          state_nxt = S_CMD;
          load      = 1'b1;
          add_chk   = 1'b1;
          nbyte     = cmd_q;
        end
      end
      S_CMD: begin
        if (byte_end) begin
          state_nxt = S_LENH;
          load      = 1'b1;
          add_chk   = 1'b1;
          nbyte     = 8'h00;
        end
      end
      S_LENH: begin
        if (byte_end) begin
          state_nxt = S_LENL;
          load      = 1'b1;
          add_chk   = 1'b1;
          nbyte     = len_l;
        end
      end
      S_LENL: begin
        if (byte_end) begin
          load = 1'b1;
          if (has_pay) begin
            state_nxt = S_PAY;
            add_chk   = 1'b1;
            nbyte     = pick(pl_q, 3'd0);
          end else begin
            state_nxt = S_CHK;
            nbyte     = chk_q;
          end
        end
      end
      S_PAY: begin
        if (byte_end) begin
          load = 1'b1;
          if (pay_q == len_m1) begin
            state_nxt = S_CHK;
            nbyte     = chk_q;
          end else begin
            add_chk = 1'b1;
            nbyte   = pick(pl_q, pay_q + 3'd1);
          end
        end
      end
      S_CHK: begin
        if (byte_end) begin
          state_nxt = S_EOP;
          load      = 1'b1;
          nbyte     = C_EOP;
        end
      end
      S_EOP: begin
        if (byte_end) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cmd_q  <= 8'h00;
      pl_q   <= 64'h0;
      cur_q  <= 8'h00;
      baud_q <= 16'h0;
      bit_q  <= 4'h0;
      pay_q  <= 3'd0;
      chk_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        if (req_valid) begin
          cmd_q <= req_cmd;
          pl_q  <= {req_addr, req_data};
        end
        chk_q <= 8'h00;
        pay_q <= 3'd0;
      end else begin
        if (add_chk) chk_q <= chk_q + nbyte;
        if (state == S_PAY && byte_end) pay_q <= pay_q + 3'd1;
      end
      // Loading a byte restarts the bit engine at its start bit.
      if (load) begin
        cur_q  <= nbyte;
        baud_q <= 16'h0;
        bit_q  <= 4'h0;
      end else if (in_byte) begin
        if (baud_q == BAUD_MAX) begin
          baud_q <= 16'h0;
          bit_q  <= (bit_q == 4'd9) ? 4'h0 : bit_q + 4'd1;
        end else begin
          baud_q <= baud_q + 16'd1;
        end
      end else begin
        baud_q <= 16'h0;
        bit_q  <= 4'h0;
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    if (in_byte) begin
      if (bit_q == 4'd0)      tx = 1'b0;
      else if (bit_q == 4'd9) tx = 1'b1;
      else                    tx = cur_q[bit_idx];
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_prog_resp_tx.sv
// Directed bench for prog_resp_tx with CLKS_PER_BIT=4.
// Decodes the serial line and checks bytes, timing and handshake.
module tb_prog_resp_tx;

  localparam int CPB = 4;
  localparam int BT  = 10 * CPB;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = 8'h00;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic        tx;
  logic        busy;
  logic        frame_done;

  prog_resp_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   cmd;
    logic [31:0]  addr;
    logic [31:0]  data;
    int           nb;
    logic [111:0] bytes;
  } vec_t;

  vec_t vec [0:2];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input int vi, input bit hold);
    int w = 0;
    while (!req_ready && w < 100) begin
      step();
      w++;
    end
    chk("ready_wait", {31'b0, req_ready}, 32'd1);
    req_cmd   = vec[vi].cmd;
    req_addr  = vec[vi].addr;
    req_data  = vec[vi].data;
    req_valid = 1'b1;
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  // Entered one cycle after acceptance; returns one cycle after DONE.
  task automatic capture_check(input int vi, input int ghost_at,
                               input int next_vi);
    logic         cap [0:1023];
    int           cyc = 0;
    bit           rdy_seen = 1'b0;
    bit           tmo = 1'b0;
    int           glitches = 0;
    logic [111:0] sh;
    logic [7:0]   eb;
    logic [7:0]   gb;
    logic         eb_bit;
    int           idx;
    chk("first_low", {31'b0, tx}, 32'd0);
    chk("busy_on", {31'b0, busy}, 32'd1);
    while (!frame_done) begin
      if (cyc >= 1000) begin
        tmo = 1'b1;
        break;
      end
      cap[cyc] = tx;
      if (req_ready) rdy_seen = 1'b1;
      if (ghost_at >= 0 && cyc == ghost_at) begin
        req_valid = 1'b1;
        req_cmd   = 8'h08;
        req_addr  = 32'h1234;
      end else if (ghost_at >= 0 && cyc == ghost_at + 1) begin
        req_valid = 1'b0;
      end
      cyc++;
      step();
    end
    chk("timeout", {31'b0, tmo}, 32'd0);
    chk("frame_cycles", cyc, vec[vi].nb * BT);
    chk("ready_low", {31'b0, rdy_seen}, 32'd0);
    for (int b = 0; b < vec[vi].nb; b++) begin
      sh = vec[vi].bytes << (8 * b);
      eb = sh[111:104];
      gb = 8'h00;
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      eb_bit = 1'b0;
        else if (k == 9) eb_bit = 1'b1;
        else             eb_bit = eb[k-1];
        for (int j = 0; j < CPB; j++) begin
          idx = b * BT + k * CPB + j;
          if (idx >= cyc) glitches++;
          else if (cap[idx] !== eb_bit) glitches++;
        end
        idx = b * BT + k * CPB + CPB / 2;
        if (k >= 1 && k <= 8 && idx < cyc) gb[k-1] = cap[idx];
      end
      chk($sformatf("byte%0d_v%0d", b, vi), {24'b0, gb}, {24'b0, eb});
    end
    chk("bit_timing", glitches, 0);
    if (next_vi >= 0) begin
      req_cmd  = vec[next_vi].cmd;
      req_addr = vec[next_vi].addr;
      req_data = vec[next_vi].data;
    end
    chk("done_tx", {31'b0, tx}, 32'd1);
    step();
    chk("done_width", {31'b0, frame_done}, 32'd0);
    chk("ready_after", {31'b0, req_ready}, 32'd1);
    chk("idle_tx", {31'b0, tx}, 32'd1);
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    vec[0] = '{8'h08, 32'h00000010, 32'hDEADBEEF, 14,
               112'h23_08_00_08_00_00_00_10_DE_AD_BE_EF_58_0D};
    vec[1] = '{8'h07, 32'h00000004, 32'hCAFEF00D, 10,
               112'h23_07_00_04_00_00_00_04_0F_0D_00_00_00_00};
    vec[2] = '{8'h55, 32'h00000099, 32'h11111111, 6,
               112'h23_55_00_00_55_0D_00_00_00_00_00_00_00_00};

    resetn    = 1'b0;
    req_valid = 1'b1;
    repeat (3) step();
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, frame_done}, 32'd0);
    req_valid = 1'b0;
    resetn    = 1'b1;
    step();

    for (int v = 0; v < 3; v++) begin
      start_req(v, 1'b0);
      capture_check(v, -1, -1);
      repeat (3) step();
    end

    // Request pulsed mid-frame must be dropped.
    start_req(1, 1'b0);
    capture_check(1, 50, -1);
    repeat (10) step();
    chk("ghost_busy", {31'b0, busy}, 32'd0);
    chk("ghost_tx", {31'b0, tx}, 32'd1);

    // Reset inside the third payload byte of a read reply.
    start_req(0, 1'b0);
    repeat (249) step();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    resetn = 1'b0;
    step();
    chk("mid_rst_tx", {31'b0, tx}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    resetn = 1'b1;
    repeat (20) step();
    chk("no_resume_busy", {31'b0, busy}, 32'd0);
    chk("no_resume_tx", {31'b0, tx}, 32'd1);
    start_req(1, 1'b0);
    capture_check(1, -1, -1);

    // Back-to-back with req_valid held high.
    start_req(1, 1'b1);
    capture_check(1, -1, 2);
    step();
    req_valid = 1'b0;
    capture_check(2, -1, -1);
    repeat (10) step();
    chk("b2b_end_busy", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
